// File: rtl/mealy_stim_tx.sv
// mealy_stim_tx
//   Serial stimulus transmitter for the 4-state Mealy sequence engine.
//   A parallel word accepted over load/ready is shifted out MSB-first on a_out,
//   one bit per clock. The engine's z response is collected into dout. A
//   cycle-exact copy of the engine runs alongside and flags any bit where the
//   observed z_in differs from the model.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   load, din    word offer; accepted when load & ready at a rising edge
//   ready        idle, able to accept a word
//   a_out        registered serial bit driving engine input 'a'
//   z_in         engine output z (combinational from engine state and a_out)
//   dout, done   captured response word, first bit in MSB; done pulses 1 cycle
//   mismatch     some bit of the last word disagreed with the model
//   err_count    saturating count of mismatched bits since reset
//   model_state  one-cold state of the internal engine model
module mealy_stim_tx #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             a_out,
  input  logic             z_in,
  output logic [WIDTH-1:0] dout,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       model_state
);

  localparam logic [3:0] S0 = 4'b1110;
  localparam logic [3:0] S1 = 4'b1101;
  localparam logic [3:0] S2 = 4'b1011;
  localparam logic [3:0] S3 = 4'b0111;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} fsm_t;

  // Engine next-state; illegal encodings recover to S0.
  function automatic logic [3:0] eng_next(input logic [3:0] s, input logic a);
    case (s)
      S0:      return a ? S3 : S0;
      S1:      return a ? S0 : S1;
      S2:      return a ? S1 : S2;
      S3:      return a ? S1 : S2;
      default: return S0;
    endcase
  endfunction

  // Engine Mealy output: S0..S2 echo 'a', S3 and illegal encodings give 0.
  function automatic logic eng_z(input logic [3:0] s, input logic a);
    case (s)
      S0, S1, S2: return a;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  fsm_t             fsm_q;
  logic [WIDTH-2:0] shreg_q;   // bits still to send, next one in MSB
  logic [WIDTH-2:0] rsp_q;     // response bits collected so far
  logic [CW-1:0]    cnt_q;
  logic             a_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] dout_q;
  logic             mis_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       mstate_q;

  logic [WIDTH-1:0] rsp_d;
  logic             zmod_d;

  always_comb begin
    rsp_d  = {rsp_q, z_in};
    zmod_d = eng_z(mstate_q, a_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q    <= IDLE;
      ready_q  <= 1'b1;
      a_q      <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      mis_q    <= 1'b0;
      err_q    <= '0;
      mstate_q <= S0;
    end else begin
      // The model follows a_out on every edge, exactly like the real engine.
      mstate_q <= eng_next(mstate_q, a_q);
      done_q   <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (load && ready_q) begin
            shreg_q <= din[WIDTH-2:0];
            a_q     <= din[WIDTH-1];
            ready_q <= 1'b0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            fsm_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // z_in belongs to the bit currently on a_out.
          rsp_q <= rsp_d[WIDTH-2:0];
          if (z_in != zmod_d) begin
            mis_q <= 1'b1;
            err_q <= sat_inc(err_q);
          end
          if (cnt_q != LAST) begin
            a_q     <= shreg_q[WIDTH-2];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q + CW'(1);
          end else begin
            dout_q  <= rsp_d;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            a_q     <= 1'b0;
            fsm_q   <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ready       = ready_q;
  assign a_out       = a_q;
  assign dout        = dout_q;
  assign done        = done_q;
  assign mismatch    = mis_q;
  assign err_count   = err_q;
  assign model_state = mstate_q;

endmodule

// File: tb/tb_mealy_stim_tx.sv
// Bench for mealy_stim_tx: a behavioural engine closes the loop (optionally
// forced to z=0), expected words are queued at each load and compared on done.
module tb_mealy_stim_tx;

  localparam int W  = 8;
  localparam int EW = 3;

  localparam logic [3:0] S0 = 4'b1110;
  localparam logic [3:0] S1 = 4'b1101;
  localparam logic [3:0] S2 = 4'b1011;
  localparam logic [3:0] S3 = 4'b0111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  din = '0;
  logic          ready, a_out, z_in, done, mismatch;
  logic [W-1:0]  dout;
  logic [EW-1:0] err_count;
  logic [3:0]    model_state;

  mealy_stim_tx #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .ready(ready),
    .a_out(a_out), .z_in(z_in), .dout(dout), .done(done), .mismatch(mismatch),
    .err_count(err_count), .model_state(model_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine transition table.
  function automatic logic [3:0] tnext(input logic [3:0] s, input logic a);
    case (s)
      S0:      return a ? S3 : S0;
      S1:      return a ? S0 : S1;
      S2:      return a ? S1 : S2;
      S3:      return a ? S1 : S2;
      default: return S0;
    endcase
  endfunction

  function automatic logic tz(input logic [3:0] s, input logic a);
    return (s == S3) ? 1'b0 : ((s == S0 || s == S1 || s == S2) ? a : 1'b0);
  endfunction

  // Behavioural engine on the DUT's serial line, sharing clock and reset.
  logic [3:0] eng_q;
  logic       z_zero = 1'b0;
  always @(posedge clk) begin
    if (!reset) eng_q <= S0;
    else        eng_q <= tnext(eng_q, a_out);
  end
  assign z_in = z_zero ? 1'b0 : tz(eng_q, a_out);

  typedef struct {
    logic [W-1:0]  dout;
    logic          mis;
    logic [EW-1:0] err;
    logic [3:0]    mst;
  } exp_t;
  exp_t sb[$];

  logic [3:0] sw_state = S0;   // model state at the end of the last word
  int         sw_err   = 0;

  // Build the expectation for one word. Idle (a=0) steps before the first bit
  // settle S3 into S2; every other state is stable under a=0.
  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    logic [3:0] s;
    int n;
    logic zb;
    s = tnext(sw_state, 1'b0);
    n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      zb = tz(s, w[i]);
      e.dout[i] = z_zero ? 1'b0 : zb;
      if (z_zero && zb) n++;
      s = tnext(s, w[i]);
    end
    sw_err = (sw_err + n > 7) ? 7 : sw_err + n;
    sw_state = s;
    e.mis = (n != 0);
    e.err = EW'(sw_err);
    e.mst = s;
    sb.push_back(e);
  endtask

  // Scoreboard consumer.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", dout, e.dout);
        check("mismatch", mismatch, e.mis);
        check("err_count", err_count, e.err);
        check("model_state", model_state, e.mst);
        check("ready_at_done", ready, 1);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #2; k++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    wait_ready();
    push_word(w);
    load = 1'b1; din = w;
    @(posedge clk); #1;
    load = 1'b0;
    wait_empty();
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", ready, 1);
    check("rst_a_out", a_out, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err", err_count, 0);
    check("rst_state", model_state, S0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_state", model_state, S0);

    // T1..T3 with a correct engine
    send(8'h00);
    send(8'hFF);
    send(8'h80);

    // first bit appears on a_out right after accept, MSB first
    wait_ready();
    push_word(8'h96);
    load = 1'b1; din = 8'h96;
    @(posedge clk); #1;
    load = 1'b0;
    check("a_bit0", a_out, 1);
    @(posedge clk); #1;
    check("a_bit1", a_out, 0);
    wait_empty();
    @(posedge clk); #1;
    check("idle_a_out", a_out, 0);

    // T4: engine output stuck at 0, then push err_count into saturation
    z_zero = 1'b1;
    send(8'hFF);
    send(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("mismatch_hold", mismatch, 1);
    check("err_sat_hold", err_count, 7);
    z_zero = 1'b0;

    // T5: load held high with a changing din during SHIFT
    wait_ready();
    push_word(8'h3C);
    load = 1'b1; din = 8'h3C;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      din = W'($urandom);
      if (sb.size() == 0) break;
    end
    load = 1'b0;
    check("hold_load_done", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    check("no_reaccept", ready, 1);

    // T6: reset during bit 3 aborts the word without a done
    wait_ready();
    load = 1'b1; din = 8'hA5;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_bit3", a_out, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", ready, 1);
    check("abort_a_out", a_out, 0);
    check("abort_done", done, 0);
    check("abort_dout", dout, 0);
    check("abort_err", err_count, 0);
    check("abort_state", model_state, S0);
    reset = 1'b1;
    sw_state = S0;
    sw_err = 0;
    repeat (12) @(posedge clk);
    send(8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed 1 expected 0");
    $fatal(1);
  end

endmodule
